// File: rtl/fp_split_seq_if.sv
// fp_split_seq_if: operand/result handshake bundle for fp_split_seq.
interface fp_split_seq_if #(
    parameter int FRAC_W = 10,
    parameter int EXP_W  = 8,
    parameter int INT_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_data;
    logic              out_valid;
    logic              out_ready;
    logic              sign_out;
    logic [INT_W-1:0]  int_part;
    logic [FRAC_W-1:0] frac_part;
    logic [EXP_W-1:0]  exp_mag;
    logic              exp_sign;
    logic              is_zero;
    logic              is_inf;
    logic              is_nan;
    logic              exp_sat;
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, sign_out, int_part, frac_part, exp_mag,
               exp_sign, is_zero, is_inf, is_nan, exp_sat
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, sign_out, int_part, frac_part, exp_mag,
               exp_sign, is_zero, is_inf, is_nan, exp_sat
    );
endinterface

// File: rtl/fp_split_seq.sv
// fp_split_seq: sequential IEEE-754 single splitter (sign, int digit, fraction, sign-magnitude exponent).
// Define ROUND_NEAREST_EN for round-to-nearest-even; default truncates the fraction.
module fp_split_seq #(
    parameter int FRAC_W = 10,
    parameter int EXP_W  = 8,
    parameter int INT_W  = 4
) (
    input logic          clk,
    input logic          rst_n,
    fp_split_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;
    localparam logic [8:0] MAX_MAG = 9'((1 << EXP_W) - 1);
    state_t            state, state_nx;
    logic [23:0]       mant;
    logic signed [8:0] exp_r;
    logic              sign_r, zero_r, inf_r, nan_r;
    logic [7:0]        e;
    logic [22:0]       m;
    logic              accept, special, up, carry, sat;
    logic [FRAC_W-1:0] frac_t;
    logic [FRAC_W:0]   frac_sum;
    logic signed [8:0] exp_fin;
    logic [8:0]        mag;
    assign e        = bus.in_data[30:23];
    assign m        = bus.in_data[22:0];
    assign bus.in_ready = state == IDLE;
    assign accept   = bus.in_valid & bus.in_ready;
    assign special  = zero_r | inf_r | nan_r;
    assign frac_t   = mant[22 -: FRAC_W];
`ifdef ROUND_NEAREST_EN
    // guard is the first dropped bit, sticky the OR of everything below it
    localparam logic [22:0] LOW_M    = (23'd1 << (23 - FRAC_W)) - 23'd1;
    localparam logic [22:0] STICKY_M = LOW_M >> 1;
    localparam logic [22:0] GUARD_M  = LOW_M ^ STICKY_M;
    assign up = |(mant[22:0] & GUARD_M) & (|(mant[22:0] & STICKY_M) | frac_t[0]);
`else
    assign up = 1'b0;
`endif
    assign frac_sum = {1'b0, frac_t} + (FRAC_W + 1)'(up);
    assign carry    = frac_sum[FRAC_W];
    assign exp_fin  = exp_r + $signed({8'd0, carry});
    assign mag      = exp_fin[8] ? 9'(-exp_fin) : 9'(exp_fin);
    assign sat      = mag > MAX_MAG;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (accept) state_nx = (e == 8'd0 && m != 23'd0) ? NORM : ROUND;
            NORM:  if (mant[22]) state_nx = ROUND;
            ROUND: state_nx = DONE;
            DONE:  if (bus.out_ready) state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mant          <= '0;
            exp_r         <= '0;
            sign_r        <= 1'b0;
            zero_r        <= 1'b0;
            inf_r         <= 1'b0;
            nan_r         <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.sign_out  <= 1'b0;
            bus.int_part  <= '0;
            bus.frac_part <= '0;
            bus.exp_mag   <= '0;
            bus.exp_sign  <= 1'b0;
            bus.is_zero   <= 1'b0;
            bus.is_inf    <= 1'b0;
            bus.is_nan    <= 1'b0;
            bus.exp_sat   <= 1'b0;
        end else begin
            if (accept) begin
                mant   <= {e != 8'd0, m};
                exp_r  <= e == 8'd0 ? -9'sd126 : $signed({1'b0, e}) - 9'sd127;
                sign_r <= bus.in_data[31];
                zero_r <= e == 8'd0 && m == 23'd0;
                inf_r  <= e == 8'hFF && m == 23'd0;
                nan_r  <= e == 8'hFF && m != 23'd0;
            end
            if (state == NORM) begin
                mant  <= mant << 1;
                exp_r <= exp_r - 9'sd1;
            end
            if (state == ROUND) begin
                bus.out_valid <= 1'b1;
                bus.sign_out  <= sign_r;
                bus.int_part  <= special ? '0 : INT_W'(1);
                bus.frac_part <= special ? '0 : frac_sum[FRAC_W-1:0];
                bus.exp_mag   <= special ? '0 : sat ? '1 : mag[EXP_W-1:0];
                bus.exp_sign  <= !special & exp_fin[8];
                bus.exp_sat   <= !special & sat;
                bus.is_zero   <= zero_r;
                bus.is_inf    <= inf_r;
                bus.is_nan    <= nan_r;
            end
            if (state == DONE && bus.out_ready) bus.out_valid <= 1'b0;
        end
    end
endmodule
